// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, ALUop classes
// and the EX/MEM pipeline register layout.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_LOGI = 2'b11;

  typedef struct packed {
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic r15;
    logic reg_write;
    logic mov_op;
  } exmem_ctrl_t;

  typedef struct packed {
    exmem_ctrl_t ctrl;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        o;
    logic [3:0]  reg_rd;
  } exmem_t;

  // R-type funct values that name a real ALU operation; anything else decodes to NOP.
  function automatic logic is_defined_op(input logic [3:0] f);
    return (f <= OP_PASS) || (f == OP_NOP);
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational signed 16-bit ALU: primary result, secondary word (MUL high
// half or DIV remainder) and an overflow / divide-by-zero flag.
module ex_alu
  import ex_pkg::*;
(
  input  logic [3:0]  operation,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        o
);

  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] prod;
  logic signed [15:0] quot;
  logic signed [15:0] rem;
  logic        [15:0] sum;
  logic        [15:0] diff;
  logic               div_zero;
  logic               div_ovf;

  assign a     = op1;
  assign b     = op2;
  assign a_ext = {{16{op1[15]}}, op1};
  assign b_ext = {{16{op2[15]}}, op2};
  assign prod  = a_ext * b_ext;
  assign quot  = a / b;
  assign rem   = a % b;
  assign sum   = op1 + op2;
  assign diff  = op1 - op2;

  assign div_zero = (op2 == 16'h0000);
  assign div_ovf  = (op1 == 16'h8000) && (op2 == 16'hFFFF);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    result    = '0;
    remainder = '0;
    o         = 1'b0;
    case (operation)
      OP_ADD: begin
        result = sum;
        o      = (op1[15] == op2[15]) && (sum[15] != op1[15]);
      end
      OP_SUB: begin
        result = diff;
        o      = (op1[15] != op2[15]) && (diff[15] != op1[15]);
      end
      OP_AND:  result = op1 & op2;
      OP_OR:   result = op1 | op2;
      OP_MUL: begin
        result    = prod[15:0];
        remainder = prod[31:16];
        o         = (prod[31:16] != {16{prod[15]}});
      end
      OP_DIV: begin
        // The two corner cases bypass the divider, whose output is meaningless there.
        if (div_zero) begin
          remainder = op1;
          o         = 1'b1;
        end else if (div_ovf) begin
          result = 16'h8000;
          o      = 1'b1;
        end else begin
          result    = quot;
          remainder = rem;
        end
      end
      OP_SLL:  result = op1 << op2[3:0];
      OP_SRL:  result = op1 >> op2[3:0];
      OP_PASS: result = op2;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, the ALU itself, and the EX/MEM pipeline
// register that feeds data memory.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ALUop,
  input  logic [3:0]  funct,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        R15_in,
  input  logic        RegWrite_in,
  input  logic        movOP_in,
  input  logic [3:0]  IDEX_RegRD,
  input  logic        FLUSH_EX,
  output logic [3:0]  operation,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        o,
  output logic        MemtoReg_out,
  output logic        MemWrite_out,
  output logic        MemRead_out,
  output logic        R15_out,
  output logic        RegWrite_out,
  output logic        movOp_out,
  output logic [15:0] ALU_Result_out,
  output logic [15:0] ALU_Remainder_out,
  output logic        o_out,
  output logic [3:0]  EXM_RegRD_out
);

  exmem_t exmem_d;
  exmem_t exmem_q;

  always_comb begin
    operation = OP_NOP;
    case (ALUop)
      ALUOP_MEM:  operation = OP_ADD;
      ALUOP_BR:   operation = OP_SUB;
      ALUOP_R:    operation = is_defined_op(funct) ? funct : OP_NOP;
      ALUOP_LOGI: operation = funct[0] ? OP_OR : OP_AND;
      default:    operation = OP_NOP;
    endcase
  end

  ex_alu u_alu (
    .operation (operation),
    .op1       (op1),
    .op2       (op2),
    .result    (result),
    .remainder (remainder),
    .o         (o)
  );

  // A flushed slot becomes an all-zero bubble: no writes, no stale data.
  always_comb begin
    exmem_d = '0;
    if (!FLUSH_EX) begin
      exmem_d.ctrl      = '{mem_to_reg: MemtoReg_in, mem_write: MemWrite_in,
                            mem_read: MemRead_in, r15: R15_in,
                            reg_write: RegWrite_in, mov_op: movOP_in};
      exmem_d.result    = result;
      exmem_d.remainder = remainder;
      exmem_d.o         = o;
      exmem_d.reg_rd    = IDEX_RegRD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign MemtoReg_out      = exmem_q.ctrl.mem_to_reg;
  assign MemWrite_out      = exmem_q.ctrl.mem_write;
  assign MemRead_out       = exmem_q.ctrl.mem_read;
  assign R15_out           = exmem_q.ctrl.r15;
  assign RegWrite_out      = exmem_q.ctrl.reg_write;
  assign movOp_out         = exmem_q.ctrl.mov_op;
  assign ALU_Result_out    = exmem_q.result;
  assign ALU_Remainder_out = exmem_q.remainder;
  assign o_out             = exmem_q.o;
  assign EXM_RegRD_out     = exmem_q.reg_rd;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases from the stage's rules plus
// randomized traffic against an arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ALUop = '0;
  logic [3:0]  funct = '0;
  logic [15:0] op1 = '0, op2 = '0;
  logic        MemtoReg_in = 0, MemWrite_in = 0, MemRead_in = 0, R15_in = 0, RegWrite_in = 0, movOP_in = 0;
  logic [3:0]  IDEX_RegRD = '0;
  logic        FLUSH_EX = 1'b0;
  logic [3:0]  operation;
  logic [15:0] result, remainder;
  logic        o;
  logic        MemtoReg_out, MemWrite_out, MemRead_out, R15_out, RegWrite_out, movOp_out;
  logic [15:0] ALU_Result_out, ALU_Remainder_out;
  logic        o_out;
  logic [3:0]  EXM_RegRD_out;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .ALUop(ALUop), .funct(funct), .op1(op1), .op2(op2),
    .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .R15_in(R15_in), .RegWrite_in(RegWrite_in), .movOP_in(movOP_in),
    .IDEX_RegRD(IDEX_RegRD), .FLUSH_EX(FLUSH_EX),
    .operation(operation), .result(result), .remainder(remainder), .o(o),
    .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out),
    .R15_out(R15_out), .RegWrite_out(RegWrite_out), .movOp_out(movOp_out),
    .ALU_Result_out(ALU_Result_out), .ALU_Remainder_out(ALU_Remainder_out),
    .o_out(o_out), .EXM_RegRD_out(EXM_RegRD_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] res;
    logic [15:0] rem;
    logic        o;
  } alu_exp_t;

  // Reference: ALU behaviour computed with wide integer arithmetic.
  function automatic alu_exp_t model(input logic [1:0] aluop, input logic [3:0] f,
                                     input logic [15:0] a, input logic [15:0] b);
    alu_exp_t e;
    longint sa, sb, r, q, m;
    int n;
    e = '0;
    case (aluop)
      2'd0: e.op = 4'd0;
      2'd1: e.op = 4'd1;
      2'd2: e.op = (f <= 4'd8 || f == 4'd15) ? f : 4'd15;
      default: e.op = f[0] ? 4'd3 : 4'd2;
    endcase
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[3:0]);
    case (e.op)
      4'd0: begin r = sa + sb; e.res = r[15:0]; e.o = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; e.res = r[15:0]; e.o = (r > 32767) || (r < -32768); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: begin
        r = sa * sb; e.res = r[15:0]; e.rem = r[31:16];
        e.o = (r > 32767) || (r < -32768);
      end
      4'd5: begin
        if (sb == 0) begin
          e.rem = a; e.o = 1'b1;
        end else begin
          q = ((sa < 0) ? -sa : sa) / ((sb < 0) ? -sb : sb);
          if ((sa < 0) != (sb < 0)) q = -q;
          m = sa - q * sb;
          e.res = q[15:0]; e.rem = m[15:0]; e.o = (q > 32767);
        end
      end
      4'd6: begin r = longint'(a) * (longint'(1) << n); e.res = r[15:0]; end
      4'd7: begin r = longint'(a) / (longint'(1) << n); e.res = r[15:0]; end
      4'd8: e.res = b;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [42:0] regs_obs();
    return {MemtoReg_out, MemWrite_out, MemRead_out, R15_out, RegWrite_out, movOp_out,
            ALU_Result_out, ALU_Remainder_out, o_out, EXM_RegRD_out};
  endfunction

  function automatic logic [36:0] comb_obs();
    return {operation, result, remainder, o};
  endfunction

  task automatic drive(input logic [1:0] aluop, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [5:0] ctrl, input logic [3:0] rd,
                       input logic flush);
    ALUop = aluop; funct = f; op1 = a; op2 = b; IDEX_RegRD = rd; FLUSH_EX = flush;
    {MemtoReg_in, MemWrite_in, MemRead_in, R15_in, RegWrite_in, movOP_in} = ctrl;
  endtask

  task automatic test_reset();
    drive(2'd2, 4'd0, 16'h1111, 16'h2222, 6'h3F, 4'hA, 1'b0);
    #3;
    checks++;
    if (regs_obs() !== 43'd0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", regs_obs());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(2'd0, 4'd5, 16'h0003, 16'h0004, 6'b000010, 4'h2, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (ALU_Result_out !== 16'h0007 || EXM_RegRD_out !== 4'h2 || RegWrite_out !== 1'b1) begin
      errors++; $display("FAIL first_capture: got res=%h rd=%h rw=%b expected 0007 2 1",
                         ALU_Result_out, EXM_RegRD_out, RegWrite_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (regs_obs() !== 43'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", regs_obs());
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (regs_obs() !== 43'd0) begin
      errors++; $display("FAIL reset_release_hold: got %h expected 0", regs_obs());
    end
    @(posedge clk); #1;
    checks++;
    if (ALU_Result_out !== 16'h0007) begin
      errors++; $display("FAIL recapture: got %h expected 0007", ALU_Result_out);
    end
  endtask

  task automatic test_overflow();
    drive(2'd2, 4'd0, 16'h7FFF, 16'h0001, 6'd0, 4'h1, 1'b0);
    #1;
    checks++;
    if ({result, o} !== {16'h8000, 1'b1}) begin
      errors++; $display("FAIL add_ovf: got %h o=%b expected 8000 o=1", result, o);
    end
    @(posedge clk); #1;
    checks++;
    if ({ALU_Result_out, o_out} !== {16'h8000, 1'b1}) begin
      errors++; $display("FAIL add_ovf_reg: got %h o=%b expected 8000 o=1", ALU_Result_out, o_out);
    end
    drive(2'd2, 4'd1, 16'h8000, 16'h0001, 6'd0, 4'h1, 1'b0);
    #1;
    checks++;
    if ({result, o} !== {16'h7FFF, 1'b1}) begin
      errors++; $display("FAIL sub_ovf: got %h o=%b expected 7fff o=1", result, o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_div();
    drive(2'd2, 4'd4, 16'h0100, 16'h0100, 6'd0, 4'h4, 1'b0);
    #1;
    checks++;
    if ({result, remainder, o} !== {16'h0000, 16'h0001, 1'b1}) begin
      errors++; $display("FAIL mul_ovf: got %h %h o=%b expected 0000 0001 o=1", result, remainder, o);
    end
    @(posedge clk); #1;
    checks++;
    if ({ALU_Result_out, ALU_Remainder_out, o_out} !== {16'h0000, 16'h0001, 1'b1}) begin
      errors++; $display("FAIL mul_reg: got %h %h o=%b expected 0000 0001 o=1",
                         ALU_Result_out, ALU_Remainder_out, o_out);
    end
    drive(2'd2, 4'd5, 16'hFFF9, 16'h0002, 6'd0, 4'h4, 1'b0);
    #1;
    checks++;
    if ({result, remainder, o} !== {16'hFFFD, 16'hFFFF, 1'b0}) begin
      errors++; $display("FAIL div_neg: got %h %h o=%b expected fffd ffff o=0", result, remainder, o);
    end
    drive(2'd2, 4'd5, 16'h0005, 16'h0000, 6'd0, 4'h4, 1'b0);
    #1;
    checks++;
    if ({result, remainder, o} !== {16'h0000, 16'h0005, 1'b1}) begin
      errors++; $display("FAIL div_zero: got %h %h o=%b expected 0000 0005 o=1", result, remainder, o);
    end
    drive(2'd2, 4'd5, 16'h8000, 16'hFFFF, 6'd0, 4'h4, 1'b0);
    #1;
    checks++;
    if ({result, remainder, o} !== {16'h8000, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL div_minneg: got %h %h o=%b expected 8000 0000 o=1", result, remainder, o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    drive(2'd0, 4'd5, 16'h0010, 16'h0003, 6'd0, 4'h0, 1'b0);
    #1;
    checks++;
    if (operation !== 4'd0 || result !== 16'h0013) begin
      errors++; $display("FAIL dec_mem: got op=%h res=%h expected 0 0013", operation, result);
    end
    drive(2'd3, 4'd1, 16'h00F0, 16'h0F00, 6'd0, 4'h0, 1'b0);
    #1;
    checks++;
    if (operation !== 4'd3 || result !== 16'h0FF0) begin
      errors++; $display("FAIL dec_ori: got op=%h res=%h expected 3 0ff0", operation, result);
    end
    drive(2'd2, 4'hA, 16'h1234, 16'h5678, 6'd0, 4'h0, 1'b0);
    #1;
    checks++;
    if (comb_obs() !== {4'hF, 16'h0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL dec_undef: got %h expected f/0/0/0", comb_obs());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    drive(2'd2, 4'd0, 16'h1000, 16'h0234, 6'h3F, 4'h3, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (regs_obs() !== 43'd0) begin
      errors++; $display("FAIL flush: got %h expected 0", regs_obs());
    end
    FLUSH_EX = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (EXM_RegRD_out !== 4'h3 || RegWrite_out !== 1'b1 || ALU_Result_out !== 16'h1234) begin
      errors++; $display("FAIL unflush: got rd=%h rw=%b res=%h expected 3 1 1234",
                         EXM_RegRD_out, RegWrite_out, ALU_Result_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(2'd2, 4'd0, 16'h0010, 16'h0020, 6'd0, 4'h5, 1'b0);
    @(posedge clk); #1;
    drive(2'd2, 4'd6, 16'h0001, 16'h0004, 6'd0, 4'h6, 1'b0);
    #1;
    checks++;
    if (ALU_Result_out !== 16'h0030) begin
      errors++; $display("FAIL b2b_add: got %h expected 0030", ALU_Result_out);
    end
    @(posedge clk); #1;
    drive(2'd2, 4'd8, 16'hFFFF, 16'h1234, 6'd0, 4'h7, 1'b0);
    #1;
    checks++;
    if (ALU_Result_out !== 16'h0010 || EXM_RegRD_out !== 4'h6) begin
      errors++; $display("FAIL b2b_sll: got %h rd=%h expected 0010 6", ALU_Result_out, EXM_RegRD_out);
    end
    @(posedge clk); #1;
    checks++;
    if (ALU_Result_out !== 16'h1234 || EXM_RegRD_out !== 4'h7) begin
      errors++; $display("FAIL b2b_pass: got %h rd=%h expected 1234 7", ALU_Result_out, EXM_RegRD_out);
    end
  endtask

  task automatic test_random();
    alu_exp_t   e;
    logic [42:0] exp_regs;
    logic [15:0] a, b;
    logic [5:0]  ctrl;
    logic [3:0]  rd;
    logic        fl;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(0, 15));
        default: ;
      endcase
      ctrl = 6'($urandom); rd = 4'($urandom); fl = ($urandom_range(0, 7) == 0);
      drive(2'($urandom), 4'($urandom), a, b, ctrl, rd, fl);
      e = model(ALUop, funct, a, b);
      exp_regs = fl ? 43'd0 : {ctrl, e.res, e.rem, e.o, rd};
      #1;
      checks++;
      if (comb_obs() !== {e.op, e.res, e.rem, e.o}) begin
        errors++; $display("FAIL rand_comb[%0d]: aluop=%b funct=%h a=%h b=%h got %h expected %h",
                           i, ALUop, funct, a, b, comb_obs(), {e.op, e.res, e.rem, e.o});
      end
      @(posedge clk); #1;
      checks++;
      if (regs_obs() !== exp_regs) begin
        errors++; $display("FAIL rand_reg[%0d]: got %h expected %h", i, regs_obs(), exp_regs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_mul_div();
    test_decode();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
